// File: rtl/ultrasonido_sched_pkg.sv
// Shared FSM encodings, 50 MHz timing defaults and elaboration helpers
// for the ultrasonic sensor scheduler.
package ultrasonido_sched_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_PUBLISH   = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;

    localparam int unsigned DEF_N_SENS      = 2;
    localparam int unsigned DEF_CNT_W       = 22;
    localparam int unsigned DEF_TRIG_CYC    = 500;
    localparam int unsigned DEF_TIMEOUT_CYC = 1500000;
    localparam int unsigned DEF_GAP_CYC     = 3000000;
    localparam int unsigned DEF_THRESH      = 15000;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((width < 32) && ((64'd1 << width) < 64'(value)))
            width = width + 1;
        return width;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ultrasonido_sched_echo_sync_edge.sv
// Two-flop synchronizer for one echo line with registered edge pulses that
// line up with the first cycle the synchronized level shows the new value.
module echo_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic echo,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= echo;
            sync <= meta;
            rise <= meta & ~sync;
            fall <= ~meta & sync;
        end
    end

endmodule

// File: rtl/ultrasonido_sched.sv
// Round-robin scheduler sharing one echo-width timer among N_SENS ultrasonic
// sensors: trigger, time the echo (with timeout), publish, then quiet gap.
module ultrasonido_sched
    import ultrasonido_sched_pkg::*;
#(
    parameter int unsigned N_SENS      = DEF_N_SENS,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TRIG_CYC    = DEF_TRIG_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
    parameter int unsigned THRESH      = DEF_THRESH,
    localparam int unsigned ID_W       = (N_SENS > 1) ? clog2(N_SENS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_SENS-1:0]       echo,
    output logic [N_SENS-1:0]       trigger,
    output logic [N_SENS*CNT_W-1:0] dist_cnt,
    output logic                    res_valid,
    output logic [ID_W-1:0]         res_id,
    output logic                    res_tmo,
    output logic [N_SENS-1:0]       near
);

    localparam int unsigned TMR_W = clog2(max3(TRIG_CYC, TIMEOUT_CYC, GAP_CYC) + 1);

    logic [N_SENS-1:0] echo_s;
    logic [N_SENS-1:0] echo_rise;
    logic [N_SENS-1:0] echo_fall;

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic             tmo_hit;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  idx_next;
    logic [ID_W-1:0]  trig_idx;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] wcnt;
    logic             sel_sync;
    logic             sel_rise;
    logic             sel_fall;

    for (genvar i = 0; i < N_SENS; i++) begin : g_sync
        echo_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .echo  (echo[i]),
            .sync  (echo_s[i]),
            .rise  (echo_rise[i]),
            .fall  (echo_fall[i])
        );
    end

    // Only the sensor owning the current slot is ever observed.
    assign sel_sync = echo_s[idx];
    assign sel_rise = echo_rise[idx];
    assign sel_fall = echo_fall[idx];
    assign idx_next = (idx == ID_W'(N_SENS - 1)) ? '0 : idx + ID_W'(1);
    assign trig_idx = (state == ST_GAP) ? idx_next : idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Next state; timeout takes priority over an edge seen in the same cycle.
    always_comb begin
        state_d = state;
        tmo_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (tmr == TMR_W'(TRIG_CYC)) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (tmr == TMR_W'(TIMEOUT_CYC)) begin
                    state_d = ST_PUBLISH;
                    tmo_hit = 1'b1;
                end else if (sel_rise) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (tmr == TMR_W'(TIMEOUT_CYC)) begin
                    state_d = ST_PUBLISH;
                    tmo_hit = 1'b1;
                end else if (sel_fall) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tmr == TMR_W'(GAP_CYC)) state_d = enable ? ST_TRIG : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase timer restarts on every state change except WAIT_RISE->MEASURE,
    // so one count covers the whole timeout window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr  <= '0;
            wcnt <= '0;
            idx  <= '0;
        end else begin
            if ((state_d != state) && (state_d != ST_MEASURE))
                tmr <= TMR_W'(1);
            else if (state != ST_IDLE)
                tmr <= tmr + TMR_W'(1);

            if ((state == ST_WAIT_RISE) && (state_d == ST_MEASURE))
                wcnt <= CNT_W'(1);
            else if ((state == ST_MEASURE) && sel_sync && (wcnt != '1))
                wcnt <= wcnt + CNT_W'(1);

            if ((state == ST_GAP) && (state_d != ST_GAP))
                idx <= idx_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trigger   <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_tmo   <= 1'b0;
            dist_cnt  <= '0;
            near      <= '0;
        end else begin
            trigger   <= (state_d == ST_TRIG) ? (N_SENS'(1) << trig_idx) : '0;
            res_valid <= (state_d == ST_PUBLISH);
            if (state_d == ST_PUBLISH) begin
                res_id  <= idx;
                res_tmo <= tmo_hit;
                dist_cnt[int'(idx)*CNT_W +: CNT_W] <= tmo_hit ? '1 : wcnt;
                near[idx] <= !tmo_hit && (wcnt < CNT_W'(THRESH));
            end
        end
    end

endmodule

// File: tb/tb_ultrasonido_sched.sv
// Bench for ultrasonido_sched: slot plan -> cycle-accurate expected outputs,
// compared every cycle, plus literal pins on the first three results.
module tb_ultrasonido_sched;

    localparam int N     = 2;
    localparam int CW    = 22;
    localparam int TRIG  = 4;
    localparam int TMO   = 200;
    localparam int GAP   = 20;
    localparam int TH    = 50;
    localparam int NSLOT = 22;
    localparam int E_IDX = 19;
    localparam int F_IDX = 20;
    localparam int G_IDX = 21;

    logic                clk;
    logic                reset;
    logic                enable;
    logic [N-1:0]        echo;
    logic [N-1:0]        trigger;
    logic [N*CW-1:0]     dist_cnt;
    logic                res_valid;
    logic [0:0]          res_id;
    logic                res_tmo;
    logic [N-1:0]        near;

    ultrasonido_sched #(
        .N_SENS(N), .CNT_W(CW), .TRIG_CYC(TRIG), .TIMEOUT_CYC(TMO),
        .GAP_CYC(GAP), .THRESH(TH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .echo      (echo),
        .trigger   (trigger),
        .dist_cnt  (dist_cnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_tmo   (res_tmo),
        .near      (near)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    // Slot plan: kind 0 = echo pulse, 1 = no echo, 2 = echo stuck high
    int sens [NSLOT];
    int kind [NSLOT];
    int dd   [NSLOT];
    int ww   [NSLOT];
    int nw   [NSLOT];
    int ts   [NSLOT];
    int ea   [NSLOT];
    int pub  [NSLOT];
    int tmo_f[NSLOT];
    int drop_cyc, reen_cyc, rst_cyc;

    logic [CW-1:0] m_dist [N] = '{default: '0};
    logic [N-1:0]  m_near = '0;

    int   q_cyc[$];
    int   q_id[$];
    int   q_tmo[$];
    int   q_d0[$];
    int   q_d1[$];
    int   q_near[$];
    int   t0cnt = 0;
    int   t1cnt = 0;

    always @(posedge clk) if (reset) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Raw echo level that the DUT samples at posedge number e.
    function automatic logic echo_at(input int s, input int e);
        logic v;
        v = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            if (sens[k] == s) begin
                if (kind[k] == 0 && e >= ea[k] + dd[k] && e < ea[k] + dd[k] + ww[k]) v = 1'b1;
                if (kind[k] == 2 && e >= ts[k] + 1 && e < ea[k] + TMO + 3) v = 1'b1;
            end else if (e >= ea[k] + 1 && e < ea[k] + 1 + nw[k]) begin
                v = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic set_slot(input int k, input int kd, input int d, input int w);
        kind[k] = kd;
        dd[k]   = d;
        ww[k]   = w;
    endtask

    task automatic plan();
        int r;
        set_slot(0, 0, 3, 30);
        set_slot(1, 0, 5, 120);
        set_slot(2, 1, 0, 0);
        set_slot(3, 2, 0, 0);
        set_slot(4, 0, 1, 196);
        set_slot(5, 0, 10, 195);
        set_slot(6, 0, 2, 49);
        set_slot(7, 0, 2, 50);
        set_slot(8, 0, 1, 1);
        for (int k = 9; k < E_IDX; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) set_slot(k, 0, int'($urandom_range(1, 40)), int'($urandom_range(1, 150)));
            else if (r < 85) set_slot(k, 1, 0, 0);
            else set_slot(k, 2, 0, 0);
        end
        set_slot(E_IDX, 0, 4, 20);
        set_slot(F_IDX, 0, 3, 10);
        set_slot(G_IDX, 0, 2, 60);
        for (int k = 0; k < NSLOT; k++) begin
            sens[k] = k % N;
            nw[k]   = int'($urandom_range(1, 8));
            if (k == 0) ts[k] = 1;
            else if (k == E_IDX + 1) ts[k] = reen_cyc + 1;
            else ts[k] = pub[k-1] + GAP + 1;
            ea[k] = ts[k] + TRIG;
            if (kind[k] == 0 && ea[k] + dd[k] + ww[k] + 2 < ea[k] + TMO) begin
                pub[k]   = ea[k] + dd[k] + ww[k] + 2;
                tmo_f[k] = 0;
            end else begin
                pub[k]   = ea[k] + TMO;
                tmo_f[k] = 1;
            end
            if (k == E_IDX) begin
                drop_cyc = ea[k] + dd[k] + 3;
                reen_cyc = pub[k] + GAP + 1 + 30;
            end
        end
        rst_cyc = ea[G_IDX] + dd[G_IDX] + 5;
    endtask

    logic [N-1:0]    c_et;
    logic            c_erv;
    int              c_eid;
    int              c_etmo;
    logic [N*CW-1:0] c_ed;

    // Per-cycle comparison against the slot plan.
    always @(negedge clk) begin
        if (chk_en) begin
            c_et   = '0;
            c_erv  = 1'b0;
            c_eid  = 0;
            c_etmo = 0;
            for (int k = 0; k < NSLOT; k++) begin
                if (cyc >= ts[k] && cyc < ts[k] + TRIG) c_et[sens[k]] = 1'b1;
                if (cyc == pub[k]) begin
                    c_erv  = 1'b1;
                    c_eid  = sens[k];
                    c_etmo = tmo_f[k];
                    m_dist[sens[k]] = (tmo_f[k] != 0) ? '1 : CW'(ww[k]);
                    m_near[sens[k]] = (tmo_f[k] == 0) && (ww[k] < TH);
                end
            end
            for (int s = 0; s < N; s++) c_ed[s*CW +: CW] = m_dist[s];
            chk("trigger", 64'(trigger), 64'(c_et));
            chk("res_valid", 64'(res_valid), 64'(c_erv));
            if (c_erv) begin
                chk("res_id", 64'(res_id), 64'(c_eid));
                chk("res_tmo", 64'(res_tmo), 64'(c_etmo));
            end
            chk("dist_cnt", 64'(dist_cnt), 64'(c_ed));
            chk("near", 64'(near), 64'(m_near));
            if (res_valid === 1'b1) begin
                q_cyc.push_back(cyc);
                q_id.push_back(int'(res_id));
                q_tmo.push_back(int'(res_tmo));
                q_d0.push_back(int'(dist_cnt[CW-1:0]));
                q_d1.push_back(int'(dist_cnt[2*CW-1:CW]));
                q_near.push_back(int'(near));
            end
            if (cyc <= 10) begin
                if (trigger[0] === 1'b1) t0cnt++;
                if (trigger[1] === 1'b1) t1cnt++;
            end
        end
    end

    initial begin
        logic reached;
        reset   = 1'b0;
        enable  = 1'b1;
        echo    = '0;
        reached = 1'b0;
        plan();

        repeat (3) @(negedge clk);
        chk("rst_trigger", 64'(trigger), 64'd0);
        chk("rst_dist", 64'(dist_cnt), 64'd0);
        chk("rst_near", 64'(near), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_tmo", 64'(res_tmo), 64'd0);

        reset  = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 30000 && !reached; i++) begin
            if (cyc == drop_cyc) enable = 1'b0;
            if (cyc == reen_cyc) enable = 1'b1;
            for (int s = 0; s < N; s++) echo[s] = echo_at(s, cyc + 1);
            if (cyc == rst_cyc) reached = 1'b1;
            else @(negedge clk);
        end
        chk("reach_reset_point", 64'(reached), 64'd1);

        // Asynchronous reset in the middle of a measurement.
        chk_en = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_trigger", 64'(trigger), 64'd0);
        chk("midrst_near", 64'(near), 64'd0);
        chk("midrst_dist", 64'(dist_cnt), 64'd0);
        chk("midrst_valid", 64'(res_valid), 64'd0);

        chk("pin_trig0_cycles", 64'(t0cnt), 64'd4);
        chk("pin_trig1_cycles", 64'(t1cnt), 64'd0);
        if (q_cyc.size() >= 3) begin
            chk("pin0_cyc", 64'(q_cyc[0]), 64'd40);
            chk("pin0_id", 64'(q_id[0]), 64'd0);
            chk("pin0_tmo", 64'(q_tmo[0]), 64'd0);
            chk("pin0_dist0", 64'(q_d0[0]), 64'd30);
            chk("pin0_near", 64'(q_near[0]), 64'd1);
            chk("pin1_cyc", 64'(q_cyc[1]), 64'd192);
            chk("pin1_id", 64'(q_id[1]), 64'd1);
            chk("pin1_tmo", 64'(q_tmo[1]), 64'd0);
            chk("pin1_dist1", 64'(q_d1[1]), 64'd120);
            chk("pin1_near", 64'(q_near[1]), 64'd1);
            chk("pin2_cyc", 64'(q_cyc[2]), 64'd417);
            chk("pin2_id", 64'(q_id[2]), 64'd0);
            chk("pin2_tmo", 64'(q_tmo[2]), 64'd1);
            chk("pin2_dist0", 64'(q_d0[2]), 64'h3FFFFF);
            chk("pin2_dist1", 64'(q_d1[2]), 64'd120);
            chk("pin2_near", 64'(q_near[2]), 64'd0);
        end else begin
            chk("pin_result_count", 64'(q_cyc.size()), 64'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
